// File: rtl/adcif.sv
// I2S capture receiver: synchronizes an external BCK/LRCK/DATA stream into clk and
// deserializes 24-bit left/right words, strobing each completed stereo pair.
module adcif #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2s_bck,
  input  logic        i2s_lrck,
  input  logic        i2s_data,
  output logic        sample_valid,
  output logic [23:0] left_data,
  output logic [23:0] right_data,
  output logic        frame_error
);

  localparam int unsigned WORD_W = 24;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    WAIT_L = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   bck_prev;
  logic                   lrck_last;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WORD_W-1:0]      shreg;
  logic [WORD_W-1:0]      left_hold;

  logic bck_s;
  logic lrck_s;
  logic data_s;
  logic bck_rise;
  logic slot_short;

  assign bck_s      = bck_sync[SYNC_STAGES-1];
  assign lrck_s     = lrck_sync[SYNC_STAGES-1];
  assign data_s     = data_sync[SYNC_STAGES-1];
  assign bck_rise   = bck_s & ~bck_prev;
  assign slot_short = (bit_cnt < CNT_W'(WORD_W));

  // Equal-depth chains keep LRCK/DATA aligned with the BCK edge that samples them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      data_sync <= '0;
      bck_prev  <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], i2s_bck};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      data_sync <= {data_sync[SYNC_STAGES-1-1:0], i2s_data};
      bck_prev  <= bck_s;
    end
  end

  // Slot tracking, capture and arming; the bit on a slot-start edge belongs to the old slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= UNSYNC;
      lrck_last    <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      if (bck_rise) begin
        if (lrck_s != lrck_last) begin
          shreg     <= '0;
          bit_cnt   <= '0;
          lrck_last <= lrck_s;
          if ((state != UNSYNC) && slot_short) begin
            frame_error <= 1'b1;
          end
          if (!lrck_last) begin
            left_hold <= shreg;
            if (state == WAIT_L) begin
              state <= WAIT_R;
            end
          end else begin
            if (state == WAIT_R) begin
              left_data    <= left_hold;
              right_data   <= shreg;
              sample_valid <= 1'b1;
              state        <= WAIT_L;
            end else if (state == UNSYNC) begin
              state <= WAIT_L;
            end
          end
        end else if (slot_short) begin
          shreg[CNT_W'(WORD_W - 1) - bit_cnt] <= data_s;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adcif.sv
// Bench for adcif: slot-level I2S driver with a word-level reference model that
// predicts every sample_valid / frame_error pulse, its clk cycle and its data.
module tb_adcif;

  localparam int unsigned SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2s_bck = 1'b0;
  logic        i2s_lrck = 1'b0;
  logic        i2s_data = 1'b0;
  logic        sample_valid;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic        frame_error;

  adcif #(.SYNC_STAGES(SS)) dut (
    .clk(clk),
    .rst(rst),
    .i2s_bck(i2s_bck),
    .i2s_lrck(i2s_lrck),
    .i2s_data(i2s_data),
    .sample_valid(sample_valid),
    .left_data(left_data),
    .right_data(right_data),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errs = 0;

  typedef struct {
    int          cyc;
    bit          v;
    bit          fe;
    logic [23:0] l;
    logic [23:0] r;
  } ev_t;

  ev_t expq[$];
  ev_t cur;

  // Reference model state (word level)
  bit          m_last;
  bit          m_synced;
  bit          m_have_left;
  logic [23:0] m_left_hold;
  bit          p_valid;
  bit          p_lr;
  int          p_n;
  logic [23:0] p_word;

  bit jitter = 1'b0;
  int half = 4;

  logic [23:0] hold_l = '0;
  logic [23:0] hold_r = '0;

  function automatic logic [23:0] captured(input logic [23:0] w, input int n);
    logic [23:0] m;
    int nd;
    nd = n - 1;
    if (nd >= 24) return w;
    m = 24'hFFFFFF;
    m = m << (24 - nd);
    return w & m;
  endfunction

  task automatic model_reset();
    m_last = 1'b0;
    m_synced = 1'b0;
    m_have_left = 1'b0;
    m_left_hold = '0;
    p_valid = 1'b0;
    expq.delete();
  endtask

  // A slot boundary closes the previous slot; outputs appear SS+1 cycles after the driven rise
  task automatic model_boundary(input bit lr, input int c);
    ev_t e;
    logic [23:0] w;
    e.cyc = c + 1 + SS;
    e.v = 1'b0;
    e.fe = 1'b0;
    e.l = '0;
    e.r = '0;
    if (p_valid) begin
      w = captured(p_word, p_n);
      e.fe = m_synced && (p_n - 1 < 24);
      if (!p_lr) begin
        m_left_hold = w;
        if (m_synced) m_have_left = 1'b1;
      end else if (m_synced && m_have_left) begin
        e.v = 1'b1;
        e.l = m_left_hold;
        e.r = w;
        m_have_left = 1'b0;
      end
      if (e.v || e.fe) expq.push_back(e);
    end
    if (!lr && m_last) m_synced = 1'b1;
    m_last = lr;
  endtask

  task automatic send_slot(input bit lr, input int n, input logic [23:0] word);
    bit boundary;
    logic d;
    int lo;
    int hi;
    boundary = (lr != m_last);
    for (int i = 0; i < n; i++) begin
      if (i == 0 || i - 1 >= 24) d = 1'($urandom_range(0, 1));
      else d = word[23 - (i - 1)];
      lo = jitter ? int'($urandom_range(2, 3)) : half;
      hi = jitter ? int'($urandom_range(2, 4)) : half;
      i2s_bck = 1'b0;
      i2s_lrck = lr;
      i2s_data = d;
      repeat (lo) @(negedge clk);
      i2s_bck = 1'b1;
      if (i == 0 && boundary) model_boundary(lr, cyc);
      repeat (hi) @(negedge clk);
    end
    p_valid = 1'b1;
    p_lr = lr;
    p_n = n;
    p_word = word;
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    assert (sample_valid === 1'b0) else begin errs++; $error("FAIL %s_valid observed=%b expected=0", tag, sample_valid); end
    vectors++;
    assert (frame_error === 1'b0) else begin errs++; $error("FAIL %s_ferr observed=%b expected=0", tag, frame_error); end
    vectors++;
    assert (left_data === 24'h0) else begin errs++; $error("FAIL %s_left observed=%h expected=000000", tag, left_data); end
    vectors++;
    assert (right_data === 24'h0) else begin errs++; $error("FAIL %s_right observed=%h expected=000000", tag, right_data); end
  endtask

  task automatic apply_reset(input int ncyc);
    i2s_bck = 1'b0;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check_zero("reset");
    end
    rst = 1'b0;
  endtask

  // Pulse monitor: every pulse must match the head of the expected queue, outputs hold otherwise
  always @(negedge clk) begin
    if (rst) begin
      hold_l = '0;
      hold_r = '0;
    end else begin
      if (expq.size() > 0) begin
        vectors++;
        assert (cyc <= expq[0].cyc) else begin
          errs++;
          $error("FAIL missed_pulse observed=none expected_cycle=%0d valid=%b ferr=%b", expq[0].cyc, expq[0].v, expq[0].fe);
          void'(expq.pop_front());
        end
      end
      if (sample_valid || frame_error) begin
        vectors++;
        assert (expq.size() > 0) else begin
          errs++;
          $error("FAIL spurious_pulse observed valid=%b ferr=%b cycle=%0d expected=none", sample_valid, frame_error, cyc);
        end
        if (expq.size() > 0) begin
          cur = expq.pop_front();
          vectors++;
          assert (cyc === cur.cyc) else begin errs++; $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, cur.cyc); end
          vectors++;
          assert (sample_valid === cur.v) else begin errs++; $error("FAIL valid observed=%b expected=%b", sample_valid, cur.v); end
          vectors++;
          assert (frame_error === cur.fe) else begin errs++; $error("FAIL frame_error observed=%b expected=%b", frame_error, cur.fe); end
          if (cur.v) begin
            vectors++;
            assert (left_data === cur.l) else begin errs++; $error("FAIL left_data observed=%h expected=%h", left_data, cur.l); end
            vectors++;
            assert (right_data === cur.r) else begin errs++; $error("FAIL right_data observed=%h expected=%h", right_data, cur.r); end
          end
        end
      end
      if (sample_valid) begin
        hold_l = left_data;
        hold_r = right_data;
      end else begin
        vectors++;
        assert (left_data === hold_l && right_data === hold_r) else begin
          errs++;
          $error("FAIL hold observed=%h/%h expected=%h/%h", left_data, right_data, hold_l, hold_r);
        end
      end
    end
  end

  initial begin
    model_reset();
    apply_reset(3);

    // Standard 32-bit slots at clk/8, starting with a partial frame
    half = 4;
    send_slot(1'b1, 32, 24'($urandom));
    for (int f = 0; f < 3; f++) begin
      send_slot(1'b0, 32, 24'h123456);
      send_slot(1'b1, 32, 24'hABCDEF);
    end

    // Extremes and channel order
    send_slot(1'b0, 32, 24'h800000);
    send_slot(1'b1, 32, 24'h7FFFFF);
    send_slot(1'b0, 32, 24'hFFFFFF);
    send_slot(1'b1, 32, 24'h000001);

    // Short 17-BCK slots: 16 data bits, left-justified
    for (int f = 0; f < 3; f++) begin
      send_slot(1'b0, 17, 24'h123400);
      send_slot(1'b1, 17, 24'hBEEF00);
    end

    // Minimum error-free 25-BCK slots at clk/4
    half = 2;
    for (int f = 0; f < 3; f++) begin
      send_slot(1'b0, 25, 24'h000001);
      send_slot(1'b1, 25, 24'hFFFFFE);
    end

    // Reset mid-frame with non-zero outputs, then re-acquire
    half = 4;
    send_slot(1'b0, 32, 24'h5A5A5A);
    vectors++;
    assert (left_data !== 24'h0) else begin errs++; $error("FAIL pre_reset_nonzero observed=%h expected=nonzero", left_data); end
    apply_reset(3);
    send_slot(1'b1, 32, 24'h111111);
    for (int f = 0; f < 2; f++) begin
      send_slot(1'b0, 32, 24'h2468AC);
      send_slot(1'b1, 32, 24'h13579B);
    end

    // Jittered BCK (period 4..7 clk) with random words and slot lengths
    jitter = 1'b1;
    for (int f = 0; f < 150; f++) begin
      send_slot(1'b0, int'($urandom_range(17, 32)), 24'($urandom));
      send_slot(1'b1, int'($urandom_range(17, 32)), 24'($urandom));
    end

    // Closing left slot flushes the last right word
    jitter = 1'b0;
    half = 2;
    send_slot(1'b0, 25, 24'h000000);
    repeat (10) @(negedge clk);
    vectors++;
    assert (expq.size() == 0) else begin errs++; $error("FAIL drain observed=%0d pending expected=0", expq.size()); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
